// File: rtl/sequence_controller.sv
// sequence_controller: round-based memory game sequencer.
// Replays the first round+1 ROM entries on the LEDs (P_SHOW cycles lit,
// P_GAP cycles blank each), then checks the player's presses against the
// same entries. Advances rounds until the last one is cleared (win) or a
// wrong press is seen (lose).
// Optional feature macro: SEQCTRL_TIMEOUT_EN -- when defined, each press in
// the USER phase must arrive within P_TIMEOUT cycles or the game is lost.
module sequence_controller #(
  parameter int P_ADDR    = 4,
  parameter int P_DATA    = 4,
  parameter int P_ROUNDS  = 16,
  parameter int P_SHOW    = 50,
  parameter int P_GAP     = 10,
  parameter int P_TIMEOUT = 500
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [P_DATA-1:0] btn,
  input  logic [P_DATA-1:0] rom_data,
  output logic [P_ADDR-1:0] rom_addr,
  output logic [P_DATA-1:0] leds,
  output logic [P_ADDR-1:0] round,
  output logic              busy,
  output logic              win,
  output logic              lose
);

  // Timer must hold the largest terminal count of any phase.
  localparam int MAX_SG = (P_SHOW > P_GAP) ? P_SHOW : P_GAP;
  localparam int MAX_T  = (MAX_SG > P_TIMEOUT) ? MAX_SG : P_TIMEOUT;
  localparam int TW     = (MAX_T < 2) ? 1 : $clog2(MAX_T);

  localparam logic [TW-1:0]     SHOW_LAST  = TW'(P_SHOW - 1);
  localparam logic [TW-1:0]     GAP_LAST   = TW'(P_GAP - 1);
  localparam logic [TW-1:0]     TIMER_ONE  = TW'(1);
  localparam logic [P_ADDR-1:0] LAST_ROUND = P_ADDR'(P_ROUNDS - 1);
  localparam logic [P_ADDR-1:0] ADDR_ONE   = P_ADDR'(1);
`ifdef SEQCTRL_TIMEOUT_EN
  localparam logic [TW-1:0]     TO_LAST    = TW'(P_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP,
    ST_USER,
    ST_WIN,
    ST_LOSE
  } state_t;

  state_t            state_q;
  logic [P_ADDR-1:0] round_q;
  logic [P_ADDR-1:0] step_q;
  logic [TW-1:0]     timer_q;

  // Game FSM: playback timing, press checking and round progression.
  always_ff @(posedge clk) begin
    if (!R) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      step_q  <= '0;
      timer_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          // Terminal states keep round/step for inspection until restart.
          if (start) begin
            round_q <= '0;
            step_q  <= '0;
            timer_q <= '0;
            state_q <= ST_SHOW;
          end
        end

        ST_SHOW: begin
          if (timer_q == SHOW_LAST) begin
            timer_q <= '0;
            state_q <= ST_GAP;
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end

        ST_GAP: begin
          if (timer_q == GAP_LAST) begin
            timer_q <= '0;
            if (step_q == round_q) begin
              step_q  <= '0;
              state_q <= ST_USER;
            end else begin
              step_q  <= step_q + ADDR_ONE;
              state_q <= ST_SHOW;
            end
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end

        ST_USER: begin
          if (btn != '0) begin
            // Exact compare also rejects any multi-hot press.
            if (btn != rom_data) begin
              state_q <= ST_LOSE;
            end else begin
              timer_q <= '0;
              if (step_q != round_q) begin
                step_q <= step_q + ADDR_ONE;
              end else if (round_q == LAST_ROUND) begin
                state_q <= ST_WIN;
              end else begin
                round_q <= round_q + ADDR_ONE;
                step_q  <= '0;
                state_q <= ST_SHOW;
              end
            end
`ifdef SEQCTRL_TIMEOUT_EN
          end else if (timer_q == TO_LAST) begin
            state_q <= ST_LOSE;
          end else begin
            timer_q <= timer_q + TIMER_ONE;
`endif
          end
        end

        default: begin
          state_q <= ST_IDLE;
          round_q <= '0;
          step_q  <= '0;
          timer_q <= '0;
        end
      endcase
    end
  end

  // Output decode: everything except leds comes straight from registers.
  assign rom_addr = step_q;
  assign round    = round_q;
  assign busy     = (state_q == ST_SHOW) || (state_q == ST_GAP);
  assign win      = (state_q == ST_WIN);
  assign lose     = (state_q == ST_LOSE);
  assign leds     = (state_q == ST_SHOW) ? rom_data : '0;

endmodule

// File: tb/tb_sequence_controller.sv
// Testbench for sequence_controller: table-driven cycle vectors for reset,
// first playback and a losing press, followed by hand-written sequences for
// a full win, multi-hot press, mid-game reset and (with SEQCTRL_TIMEOUT_EN)
// the press timeout.
module tb_sequence_controller;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn = 4'd0;
  logic [3:0] rom_data;
  logic [3:0] rom_addr;
  logic [3:0] leds;
  logic [3:0] round;
  logic       busy;
  logic       win;
  logic       lose;

  logic [3:0] rom [16];

  int checks = 0;
  int errors = 0;

  sequence_controller #(
    .P_ADDR(4), .P_DATA(4), .P_ROUNDS(3),
    .P_SHOW(3), .P_GAP(2), .P_TIMEOUT(5)
  ) dut (
    .clk(clk), .R(R), .start(start), .btn(btn), .rom_data(rom_data),
    .rom_addr(rom_addr), .leds(leds), .round(round),
    .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  typedef struct {
    logic       r;
    logic       st;
    logic [3:0] b;
    logic [3:0] addr;
    logic [3:0] led;
    logic [3:0] rnd;
    logic       bsy;
    logic       wn;
    logic       ls;
  } vec_t;

  vec_t vecs [24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic press(input logic [3:0] v);
    btn = v;
    tick();
    btn = 4'd0;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Follows a playback from its first busy cycle; checks length and LED pattern.
  task automatic playback(input int rnd, input string name);
    int n = 0;
    int bad = 0;
    int e;
    int ph;
    logic [3:0] exp;
    while (busy === 1'b1 && n < 100) begin
      e = n / 5;
      ph = n % 5;
      exp = (ph < 3 && e <= rnd) ? rom[e] : 4'd0;
      if (leds !== exp) bad++;
      n++;
      tick();
    end
    chk({name, " length"}, n, (rnd + 1) * 5);
    chk({name, " leds"}, bad, 0);
    chk({name, " user round"}, {28'd0, round}, rnd);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'd0;
    rom[0] = 4'b0001;
    rom[1] = 4'b0100;
    rom[2] = 4'b0010;

    //            r     st    b     addr  leds  rnd   bsy   wn    ls
    vecs[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'h1, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 4'h0, 4'h1, 4'h4, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 4'h0, 4'h1, 4'h4, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 4'h0, 4'h1, 4'h4, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 4'h4, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b1};
    vecs[23] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0};

    #1;
    // Per-cycle vectors: inputs before the edge, outputs checked after it.
    for (int i = 0; i < 24; i++) begin
      R = vecs[i].r;
      start = vecs[i].st;
      btn = vecs[i].b;
      tick();
      chk($sformatf("vec%0d {addr,leds,round,busy,win,lose}", i),
          {17'd0, rom_addr, leds, round, busy, win, lose},
          {17'd0, vecs[i].addr, vecs[i].led, vecs[i].rnd, vecs[i].bsy, vecs[i].wn, vecs[i].ls});
    end
    start = 1'b0;
    btn = 4'd0;

    // Full winning playthrough, continuing from the restart in the last vector.
    playback(0, "win r0");
    press(4'b0001);
    chk("win r1 begins", {26'd0, round, busy, lose}, {26'd0, 4'd1, 1'b1, 1'b0});
    playback(1, "win r1");
    press(4'b0001);
    chk("win r1 step1 addr", {27'd0, rom_addr, busy}, {27'd0, 4'd1, 1'b0});
    press(4'b0100);
    chk("win r2 begins", {26'd0, round, busy, lose}, {26'd0, 4'd2, 1'b1, 1'b0});
    playback(2, "win r2");
    press(4'b0001);
    press(4'b0100);
    chk("win r2 step2 addr", {27'd0, rom_addr, win}, {27'd0, 4'd2, 1'b0});
    press(4'b0010);
    chk("win asserted", {26'd0, round, win, lose}, {26'd0, 4'd2, 1'b1, 1'b0});
    press(4'b0001);
    chk("win holds on btn", {27'd0, rom_addr, win}, {27'd0, 4'd2, 1'b1});
    start_game();
    chk("win cleared by start", {26'd0, round, win, busy}, {26'd0, 4'd0, 1'b0, 1'b1});

    // Multi-hot press in USER loses.
    playback(0, "multihot r0");
    press(4'b0011);
    chk("multihot lose", {30'd0, lose, win}, {30'd0, 1'b1, 1'b0});

    // Reset while in the GAP of round 2.
    start_game();
    playback(0, "rst r0");
    press(4'b0001);
    playback(1, "rst r1");
    press(4'b0001);
    press(4'b0100);
    repeat (3) tick();
    chk("rst in gap r2", {26'd0, round, busy, leds}, {26'd0, 4'd2, 1'b1, 4'd0});
    R = 1'b0;
    tick();
    R = 1'b1;
    chk("mid-game reset", {17'd0, rom_addr, leds, round, busy, win, lose}, 32'd0);
    tick();
    tick();
    chk("idle after reset", {17'd0, rom_addr, leds, round, busy, win, lose}, 32'd0);

`ifdef SEQCTRL_TIMEOUT_EN
    // No press for P_TIMEOUT cycles loses; a press on the last cycle wins priority.
    start_game();
    playback(0, "timeout r0");
    repeat (4) tick();
    chk("timeout not yet", {31'd0, lose}, 32'd0);
    tick();
    chk("timeout lose", {31'd0, lose}, 32'd1);
    start_game();
    playback(0, "timeout prio r0");
    repeat (4) tick();
    press(4'b0001);
    chk("press beats timeout", {27'd0, round, lose}, {27'd0, 4'd1, 1'b0});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
